// File: rtl/mxint_block_accumulator.sv
// mxint_block_accumulator
// Sums IN_DEPTH consecutive MX blocks (BLOCK_SIZE signed mantissas sharing one
// exponent) into a single MX block. Each incoming block is aligned to the
// largest exponent seen so far in the group. UNDERFLOW_BITS fractional guard
// bits keep precision when the smaller-exponent operand is shifted right.
module mxint_block_accumulator #(
   parameter int DATA_IN_0_PRECISION_0 = 4,
   parameter int DATA_IN_0_PRECISION_1 = 8,
   parameter int BLOCK_SIZE            = 1,
   parameter int IN_DEPTH              = 8,
   parameter int UNDERFLOW_BITS        = 4,
   localparam int ACC_W = DATA_IN_0_PRECISION_0 + $clog2(IN_DEPTH) + UNDERFLOW_BITS
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0]  mdata_in_0,
   input  logic [DATA_IN_0_PRECISION_1-1:0]                  edata_in_0,
   input  logic                                              data_in_0_valid,
   output logic                                              data_in_0_ready,
   output logic [BLOCK_SIZE-1:0][ACC_W-1:0]                  mdata_out_0,
   output logic [DATA_IN_0_PRECISION_1-1:0]                  edata_out_0,
   output logic                                              data_out_0_valid,
   input  logic                                              data_out_0_ready
);

   localparam int P0    = DATA_IN_0_PRECISION_0;
   localparam int P1    = DATA_IN_0_PRECISION_1;
   localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

   // Arithmetic right shift (floor); shifts of ACC_W or more collapse to the sign fill.
   function automatic logic [ACC_W-1:0] asr_fill(input logic [ACC_W-1:0] v,
                                                 input logic [P1-1:0]    sh);
      logic [ACC_W-1:0] r;
      if (32'(sh) >= 32'(ACC_W)) begin
         r = {ACC_W{v[ACC_W-1]}};
      end else begin
         r = ACC_W'($signed(v) >>> sh);
      end
      return r;
   endfunction

   // Sign-extend a mantissa to the accumulator width and place it above the guard bits.
   function automatic logic [ACC_W-1:0] extend_mant(input logic [P0-1:0] m);
      logic [ACC_W-1:0] r;
      r = ACC_W'($signed(m));
      r = r << UNDERFLOW_BITS;
      return r;
   endfunction

   logic [BLOCK_SIZE-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [BLOCK_SIZE-1:0][ACC_W-1:0] mout_q, mout_d;
   logic [BLOCK_SIZE-1:0][ACC_W-1:0] sum_s;
   logic [P1-1:0]                    exp_q, exp_d;
   logic [P1-1:0]                    eout_q, eout_d;
   logic [P1-1:0]                    shift_s;
   logic [P1-1:0]                    new_exp_s;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic                             ovalid_q, ovalid_d;
   logic                             accept_s;
   logic                             first_s;
   logic                             exp_gt_s;
   logic [ACC_W-1:0]                 x_s;

   assign data_in_0_ready  = ~rst & ~ovalid_q;
   assign accept_s         = data_in_0_valid & data_in_0_ready;
   assign mdata_out_0      = mout_q;
   assign edata_out_0      = eout_q;
   assign data_out_0_valid = ovalid_q;

   // Alignment datapath: exponent compare, shared shift distance and per-lane sums.
   always_comb begin
      sum_s     = '0;
      x_s       = '0;
      first_s   = (cnt_q == {CNT_W{1'b0}});
      exp_gt_s  = (edata_in_0 > exp_q);
      if (exp_gt_s) begin
         shift_s = edata_in_0 - exp_q;
      end else begin
         shift_s = exp_q - edata_in_0;
      end
      if (first_s || exp_gt_s) begin
         new_exp_s = edata_in_0;
      end else begin
         new_exp_s = exp_q;
      end
      for (int l = 0; l < BLOCK_SIZE; l++) begin
         x_s = extend_mant(mdata_in_0[l]);
         if (first_s) begin
            sum_s[l] = x_s;
         end else if (exp_gt_s) begin
            sum_s[l] = asr_fill(acc_q[l], shift_s) + x_s;
         end else begin
            sum_s[l] = acc_q[l] + asr_fill(x_s, shift_s);
         end
      end
   end

   // Next-state: accumulate accepted beats, publish the group result, retire it on handshake.
   always_comb begin
      acc_d    = acc_q;
      exp_d    = exp_q;
      cnt_d    = cnt_q;
      mout_d   = mout_q;
      eout_d   = eout_q;
      ovalid_d = ovalid_q;
      if (accept_s) begin
         acc_d = sum_s;
         exp_d = new_exp_s;
         if (cnt_q == LAST_CNT) begin
            cnt_d    = {CNT_W{1'b0}};
            mout_d   = sum_s;
            eout_d   = new_exp_s;
            ovalid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (ovalid_q && data_out_0_ready) begin
         ovalid_d = 1'b0;
      end else begin
         ovalid_d = ovalid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         exp_q    <= {P1{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         mout_q   <= '0;
         eout_q   <= {P1{1'b0}};
         ovalid_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         exp_q    <= exp_d;
         cnt_q    <= cnt_d;
         mout_q   <= mout_d;
         eout_q   <= eout_d;
         ovalid_q <= ovalid_d;
      end
   end

endmodule

// File: tb/tb_mxint_block_accumulator.sv
// Self-checking bench for mxint_block_accumulator (P0=4, P1=8, 2 lanes,
// depth 4, 4 guard bits -> 10-bit accumulator).
module tb_mxint_block_accumulator;

   localparam int P0 = 4;
   localparam int P1 = 8;
   localparam int BS = 2;
   localparam int D  = 4;
   localparam int UB = 4;
   localparam int AW = 10;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [BS-1:0][P0-1:0]   mdata_in_0;
   logic [P1-1:0]           edata_in_0;
   logic                    data_in_0_valid;
   logic                    data_in_0_ready;
   logic [BS-1:0][AW-1:0]   mdata_out_0;
   logic [P1-1:0]           edata_out_0;
   logic                    data_out_0_valid;
   logic                    data_out_0_ready;

   mxint_block_accumulator #(
      .DATA_IN_0_PRECISION_0(P0),
      .DATA_IN_0_PRECISION_1(P1),
      .BLOCK_SIZE(BS),
      .IN_DEPTH(D),
      .UNDERFLOW_BITS(UB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mdata_in_0(mdata_in_0),
      .edata_in_0(edata_in_0),
      .data_in_0_valid(data_in_0_valid),
      .data_in_0_ready(data_in_0_ready),
      .mdata_out_0(mdata_out_0),
      .edata_out_0(edata_out_0),
      .data_out_0_valid(data_out_0_valid),
      .data_out_0_ready(data_out_0_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m0;
      int m1;
      int e;
   } res_t;

   typedef struct {
      int e;
      int m0;
      int m1;
   } beat_t;

   res_t  sb_q[$];
   res_t  mon_r;
   int    checks = 0;
   int    errors = 0;
   bit    rand_rdy = 1'b0;

   // reference model state
   int    m_acc0, m_acc1, m_exp, m_cnt;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int wrap_aw(input int v);
      int t;
      t = v & ((1 << AW) - 1);
      return (t >= (1 << (AW - 1))) ? t - (1 << AW) : t;
   endfunction

   function automatic int ashr(input int v, input int d);
      if (d >= AW) return (v < 0) ? -1 : 0;
      return v >>> d;
   endfunction

   task automatic model_beat(input int e, input int m0, input int m1);
      int x0, x1;
      x0 = m0 * 16;
      x1 = m1 * 16;
      if (m_cnt == 0) begin
         m_acc0 = x0; m_acc1 = x1; m_exp = e;
      end else if (e > m_exp) begin
         m_acc0 = wrap_aw(ashr(m_acc0, e - m_exp) + x0);
         m_acc1 = wrap_aw(ashr(m_acc1, e - m_exp) + x1);
         m_exp  = e;
      end else begin
         m_acc0 = wrap_aw(m_acc0 + ashr(x0, m_exp - e));
         m_acc1 = wrap_aw(m_acc1 + ashr(x1, m_exp - e));
      end
      m_cnt++;
      if (m_cnt == D) begin
         sb_q.push_back('{m0: m_acc0, m1: m_acc1, e: m_exp});
         m_cnt = 0;
      end
   endtask

   // Output monitor: every completed output handshake is compared against the scoreboard.
   always @(negedge clk) begin
      if (data_out_0_valid && data_out_0_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got lane0 %0d, required no output",
                     int'($signed(mdata_out_0[0])));
         end else begin
            mon_r = sb_q.pop_front();
            chk("out_lane0", int'($signed(mdata_out_0[0])), mon_r.m0);
            chk("out_lane1", int'($signed(mdata_out_0[1])), mon_r.m1);
            chk("out_exp", int'(edata_out_0), mon_r.e);
         end
      end
   end

   task automatic drive_beat(input int e, input int m0, input int m1, input bit use_model);
      bit acc;
      int n;
      edata_in_0      = 8'(e);
      mdata_in_0[0]   = 4'(m0);
      mdata_in_0[1]   = 4'(m1);
      data_in_0_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = data_in_0_ready;
         @(posedge clk);
         #1;
         n++;
         if (rand_rdy) data_out_0_ready = ($urandom_range(0, 3) != 0);
      end
      data_in_0_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: got no acceptance in %0d cycles, required acceptance", n);
      end else if (use_model) begin
         model_beat(e, m0, m1);
      end
   endtask

   beat_t tbl_beats[16];
   res_t  tbl_res[4];
   int    e_r, m0_r, m1_r;

   initial begin
      // directed vector table: four groups of four beats, expected results from hand calculation
      tbl_beats = '{
         '{5, 1, -2}, '{5, 1, -2}, '{5, 1, -2}, '{5, 1, -2},
         '{3, 4, -1}, '{5, 4, -1}, '{5, 0, -1}, '{4, 2, -1},
         '{10, 1, -8}, '{0, 7, -8}, '{0, -1, 7}, '{10, 0, 1},
         '{0, -8, 7}, '{0, -8, 7}, '{0, -8, 7}, '{0, -8, 7}
      };
      tbl_res = '{
         '{64, -128, 5},
         '{96, -44, 5},
         '{15, -113, 10},
         '{-512, 448, 0}
      };

      rst              = 1'b1;
      data_in_0_valid  = 1'b0;
      edata_in_0       = 8'd0;
      mdata_in_0       = '0;
      data_out_0_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", int'(data_in_0_ready), 0);
      chk("reset_out_valid", int'(data_out_0_valid), 0);
      chk("reset_mdata", int'(mdata_out_0), 0);
      chk("reset_edata", int'(edata_out_0), 0);
      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", int'(data_in_0_ready), 1);

      // table-driven groups with latency and bubble checks
      for (int g = 0; g < 4; g++) begin
         sb_q.push_back(tbl_res[g]);
         for (int b = 0; b < D; b++)
            drive_beat(tbl_beats[g*D+b].e, tbl_beats[g*D+b].m0, tbl_beats[g*D+b].m1, 1'b0);
         chk("latency_out_valid", int'(data_out_0_valid), 1);
         chk("pending_in_ready", int'(data_in_0_ready), 0);
         @(posedge clk);
         #1;
         chk("taken_out_valid", int'(data_out_0_valid), 0);
         chk("bubble_in_ready", int'(data_in_0_ready), 1);
      end

      // backpressure: result held while input valid is offered and ignored
      sb_q.push_back('{128, 192, 1});
      sb_q.push_back('{-64, 64, 2});
      data_out_0_ready = 1'b0;
      for (int b = 0; b < D; b++) drive_beat(1, 2, 3, 1'b0);
      edata_in_0      = 8'd2;
      mdata_in_0[0]   = 4'(-1);
      mdata_in_0[1]   = 4'(1);
      data_in_0_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_out_valid", int'(data_out_0_valid), 1);
         chk("bp_in_ready", int'(data_in_0_ready), 0);
         chk("bp_lane0_stable", int'($signed(mdata_out_0[0])), 128);
         chk("bp_lane1_stable", int'($signed(mdata_out_0[1])), 192);
         chk("bp_exp_stable", int'(edata_out_0), 1);
         @(posedge clk);
         #1;
      end
      data_out_0_ready = 1'b1;
      for (int b = 0; b < D; b++) drive_beat(2, -1, 1, 1'b0);
      @(posedge clk);
      #1;

      // reset while a result is pending drops it
      data_out_0_ready = 1'b0;
      for (int b = 0; b < D; b++) drive_beat(0, 3, 3, 1'b0);
      chk("drop_pending_valid_before", int'(data_out_0_valid), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("drop_pending_valid_after", int'(data_out_0_valid), 0);
      chk("drop_pending_mdata", int'(mdata_out_0), 0);
      rst = 1'b0;
      data_out_0_ready = 1'b1;

      // reset mid-group discards the partial sum
      drive_beat(3, 5, 5, 1'b0);
      drive_beat(3, 5, 5, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midgroup_rst_in_ready", int'(data_in_0_ready), 0);
      rst = 1'b0;
      sb_q.push_back('{64, 64, 0});
      for (int b = 0; b < D; b++) drive_beat(0, 1, 1, 1'b0);
      @(posedge clk);
      #1;

      // random data, random input gaps and random output backpressure against the model
      m_cnt    = 0;
      rand_rdy = 1'b1;
      for (int g = 0; g < 200; g++) begin
         for (int b = 0; b < D; b++) begin
            for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
               @(posedge clk);
               #1;
               data_out_0_ready = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 1) e_r = $urandom_range(0, 15);
            else e_r = $urandom_range(0, 255);
            m0_r = int'($urandom_range(0, 15)) - 8;
            m1_r = int'($urandom_range(0, 15)) - 8;
            drive_beat(e_r, m0_r, m1_r, 1'b1);
         end
      end
      rand_rdy = 1'b0;
      data_out_0_ready = 1'b1;
      for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
